float_point_divider: RTL and testbench

Sequential IEEE-754 single-precision divider computing oZ = iA / iB. It accepts one operand pair per operation on a valid strobe and returns a rounded result with a one-cycle done pulse after a fixed latency. It sits beside the FP add/multiply units and shares their iX/oX port style.

---
 rtl/float_point_divider.sv | 206 ++++++++++++++++++++
 tb/tb_float_point_divider.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/float_point_divider.sv
// IEEE-754 single-precision sequential divider (oZ = iA / iB), 28-cycle latency.
// Define FPDIV_EXC_FLAGS_EN to add oFlags = {invalid, divbyzero, overflow, underflow}.
`timescale 1ns/1ps
module float_point_divider (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] iA,
    input  logic [31:0] iB,
    input  logic        iValid,
    output logic        oDone,
    output logic [31:0] oZ
`ifdef FPDIV_EXC_FLAGS_EN
    ,
    output logic [3:0]  oFlags
`endif
);

    typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;

    state_t state, stateNext;

    logic               sign;
    logic signed [9:0]  expR;
    logic [23:0]        divisor;
    logic [25:0]        rem;
    logic [25:0]        quo;
    logic [4:0]         cnt;
    logic               special;
    logic [31:0]        spcZ;
    logic [31:0]        res;

    logic        sA, sB, aZero, bZero, aInf, bInf, aNan, bNan, aLess, spcU;
    logic [7:0]  eA, eB;
    logic [23:0] mA, mB;
    logic signed [9:0] expU;
    logic [25:0] remInit;
    logic [31:0] zU;

    assign sA    = iA[31];
    assign sB    = iB[31];
    assign eA    = iA[30:23];
    assign eB    = iB[30:23];
    assign aZero = (eA == 8'd0);
    assign bZero = (eB == 8'd0);
    assign aInf  = (eA == 8'hFF) && (iA[22:0] == 23'd0);
    assign bInf  = (eB == 8'hFF) && (iB[22:0] == 23'd0);
    assign aNan  = (eA == 8'hFF) && (iA[22:0] != 23'd0);
    assign bNan  = (eB == 8'hFF) && (iB[22:0] != 23'd0);
    assign mA    = {1'b1, iA[22:0]};
    assign mB    = {1'b1, iB[22:0]};
    assign aLess = (mA < mB);
    assign expU  = {2'b00, eA} - {2'b00, eB} + 10'd127 - {9'd0, aLess};
    // Pre-normalise so the quotient always lands in [1,2)
    assign remInit = aLess ? {1'b0, mA, 1'b0} : {2'b00, mA};

`ifdef FPDIV_EXC_FLAGS_EN
    logic [3:0] fU, spcF, normF, resF;
`endif

    always_comb begin
        spcU = 1'b1;
        zU   = 32'h7FC00000;
`ifdef FPDIV_EXC_FLAGS_EN
        fU   = 4'b1000;
`endif
        if (aNan || bNan || (aZero && bZero) || (aInf && bInf)) begin
            zU = 32'h7FC00000;
        end else if (aInf) begin
            zU = {sA ^ sB, 8'hFF, 23'd0};
`ifdef FPDIV_EXC_FLAGS_EN
            fU = 4'b0000;
`endif
        end else if (bZero) begin
            zU = {sA ^ sB, 8'hFF, 23'd0};
`ifdef FPDIV_EXC_FLAGS_EN
            fU = 4'b0100;
`endif
        end else if (aZero || bInf) begin
            zU = {sA ^ sB, 31'd0};
`ifdef FPDIV_EXC_FLAGS_EN
            fU = 4'b0000;
`endif
        end else begin
            spcU = 1'b0;
`ifdef FPDIV_EXC_FLAGS_EN
            fU   = 4'b0000;
`endif
        end
    end

    logic [23:0]       mant;
    logic              roundUp;
    logic [24:0]       mantR;
    logic signed [9:0] expN;
    logic [22:0]       fracN;
    logic [31:0]       normZ;

    assign mant    = quo[25:2];
    assign roundUp = quo[1] & (quo[0] | (rem != 26'd0) | mant[0]);
    assign mantR   = {1'b0, mant} + {24'd0, roundUp};
    assign expN    = expR + (mantR[24] ? 10'sd1 : 10'sd0);
    assign fracN   = mantR[24] ? mantR[23:1] : mantR[22:0];

    always_comb begin
        normZ = {sign, expN[7:0], fracN};
`ifdef FPDIV_EXC_FLAGS_EN
        normF = 4'b0000;
`endif
        if (special) begin
            normZ = spcZ;
`ifdef FPDIV_EXC_FLAGS_EN
            normF = spcF;
`endif
        end else if (expN >= 10'sd255) begin
            normZ = {sign, 8'hFF, 23'd0};
`ifdef FPDIV_EXC_FLAGS_EN
            normF = 4'b0010;
`endif
        end else if (expN <= 10'sd0) begin
            normZ = {sign, 31'd0};
`ifdef FPDIV_EXC_FLAGS_EN
            normF = 4'b0001;
`endif
        end
    end

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) state <= IDLE;
        else        state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE: if (iValid) stateNext = DIV;
            DIV:  if (cnt == 5'd25) stateNext = NORM;
            NORM: stateNext = DONE;
            DONE: stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            sign    <= 1'b0;
            expR    <= '0;
            divisor <= '0;
            rem     <= '0;
            quo     <= '0;
            cnt     <= '0;
            special <= 1'b0;
            spcZ    <= '0;
            res     <= '0;
            oZ      <= '0;
            oDone   <= 1'b0;
`ifdef FPDIV_EXC_FLAGS_EN
            spcF    <= '0;
            resF    <= '0;
            oFlags  <= '0;
`endif
        end else begin
            oDone <= 1'b0;
            unique case (state)
                IDLE: if (iValid) begin
                    sign    <= sA ^ sB;
                    expR    <= expU;
                    divisor <= mB;
                    rem     <= remInit;
                    quo     <= '0;
                    cnt     <= '0;
                    special <= spcU;
                    spcZ    <= zU;
`ifdef FPDIV_EXC_FLAGS_EN
                    spcF    <= fU;
`endif
                end
                DIV: begin
                    // Restoring step: one quotient bit per cycle, MSB first
                    if (rem >= {2'b00, divisor}) begin
                        rem <= (rem - {2'b00, divisor}) << 1;
                        quo <= {quo[24:0], 1'b1};
                    end else begin
                        rem <= rem << 1;
                        quo <= {quo[24:0], 1'b0};
                    end
                    cnt <= cnt + 5'd1;
                end
                NORM: begin
                    res  <= normZ;
`ifdef FPDIV_EXC_FLAGS_EN
                    resF <= normF;
`endif
                end
                DONE: begin
                    oZ    <= res;
                    oDone <= 1'b1;
`ifdef FPDIV_EXC_FLAGS_EN
                    oFlags <= resF;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_float_point_divider.sv
// Directed scoreboard bench for float_point_divider.
`timescale 1ns/1ps
module tb_float_point_divider;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] iA, iB;
    logic        iValid;
    logic        oDone;
    logic [31:0] oZ;
`ifdef FPDIV_EXC_FLAGS_EN
    logic [3:0]  oFlags;
`endif

    int checks = 0;
    int errors = 0;
    int doneCount = 0;
    logic [31:0] sbZ[$];
    logic [3:0]  sbF[$];

    float_point_divider dut (
        .clk(clk),
        .resetn(resetn),
        .iA(iA),
        .iB(iB),
        .iValid(iValid),
        .oDone(oDone),
        .oZ(oZ)
`ifdef FPDIV_EXC_FLAGS_EN
        ,
        .oFlags(oFlags)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (oDone === 1'b1) doneCount++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic waitDone(input string tag, input int already);
        int lat;
        logic got;
        logic [31:0] ez;
        logic [3:0] ef;
        lat = already;
        got = 1'b0;
        while (!got && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (oDone === 1'b1) got = 1'b1;
        end
        chk({tag, " done"}, {31'd0, got}, 32'd1);
        ez = 32'hx;
        ef = 4'hx;
        if (sbZ.size() > 0) begin
            ez = sbZ.pop_front();
            ef = sbF.pop_front();
        end
        if (got) begin
            chk({tag, " latency"}, lat, 28);
            chk({tag, " oZ"}, oZ, ez);
`ifdef FPDIV_EXC_FLAGS_EN
            chk({tag, " flags"}, {28'd0, oFlags}, {28'd0, ef});
`endif
            @(posedge clk);
            #1;
            chk({tag, " pulse"}, {31'd0, oDone}, 32'd0);
            chk({tag, " hold"}, oZ, ez);
        end
    endtask

    task automatic runOp(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] z, input logic [3:0] f);
        @(negedge clk);
        iA = a;
        iB = b;
        iValid = 1'b1;
        @(posedge clk);
        sbZ.push_back(z);
        sbF.push_back(f);
        #1;
        iValid = 1'b0;
        iA = $urandom;
        iB = $urandom;
        waitDone(tag, 0);
    endtask

    initial begin
        int start;
        resetn = 1'b1;
        iValid = 1'b0;
        iA = '0;
        iB = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset oDone", {31'd0, oDone}, 32'd0);
        chk("reset oZ", oZ, 32'd0);
        resetn = 1'b0;
        @(negedge clk);
        chk("idle oDone", {31'd0, oDone}, 32'd0);

        runOp("inf/2^125", 32'h7F800000, 32'h7E000000, 32'h7F800000, 4'b0000);
        runOp("1.5/0.5", 32'h3FC00000, 32'h3F000000, 32'h40400000, 4'b0000);
        runOp("-425/8.5", 32'hC3D48000, 32'h41080000, 32'hC2480000, 4'b0000);
        runOp("1/3", 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000);
        runOp("0/0", 32'h00000000, 32'h00000000, 32'h7FC00000, 4'b1000);
        runOp("1/0", 32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0100);
        runOp("-1/0", 32'hBF800000, 32'h00000000, 32'hFF800000, 4'b0100);
        runOp("overflow", 32'h7F000000, 32'h00800000, 32'h7F800000, 4'b0010);
        runOp("underflow", 32'h00800000, 32'h7F000000, 32'h00000000, 4'b0001);
        runOp("0/2", 32'h00000000, 32'h40000000, 32'h00000000, 4'b0000);
        runOp("2/-inf", 32'h40000000, 32'hFF800000, 32'h80000000, 4'b0000);
        runOp("nan/1", 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b1000);
        runOp("subnormal/1", 32'h00400000, 32'h3F800000, 32'h00000000, 4'b0000);

        start = doneCount;
        @(negedge clk);
        iA = 32'h3FC00000;
        iB = 32'h3F000000;
        iValid = 1'b1;
        @(posedge clk);
        sbZ.push_back(32'h40400000);
        sbF.push_back(4'b0000);
        #1;
        iValid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        iA = 32'h3F800000;
        iB = 32'h40400000;
        iValid = 1'b1;
        @(posedge clk);
        #1;
        iValid = 1'b0;
        waitDone("repulse", 6);
        repeat (40) @(posedge clk);
        #1;
        chk("repulse count", doneCount - start, 1);

        start = doneCount;
        @(negedge clk);
        iA = 32'h3F800000;
        iB = 32'h40400000;
        iValid = 1'b1;
        @(posedge clk);
        #1;
        iValid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("midreset oDone", {31'd0, oDone}, 32'd0);
        chk("midreset oZ", oZ, 32'd0);
        @(negedge clk);
        resetn = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("midreset no done", doneCount - start, 0);
        chk("midreset oZ hold", oZ, 32'd0);

        runOp("fresh 1.5/0.5", 32'h3FC00000, 32'h3F000000, 32'h40400000, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
